fetch_redirect_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 16-bit five-stage datapath. It holds the PC, drives the instruction-memory address, and captures the fetched instruction into IF/ID. It consumes the ID-stage branch-resolution flush (`BranchingSoFlush`) and the hazard unit's stall. On a taken branch or jump it redirects the PC to the resolved target and squashes the wrong-path instruction.

---
 rtl/fetch_redirect_unit.sv | 72 +++++++
 tb/tb_fetch_redirect_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: PC register, fetch addressing and IF/ID register with branch redirect/squash
//   clk, rst                 : clock, asynchronous active-high reset
//   BranchingSoFlush, BranchTarget : ID-stage redirect request and target (bit 0 forced to 0)
//   Stall                    : hazard hold, overridden by a redirect
//   InstrAddr, InstrData     : instruction-memory address (current PC) and same-cycle read data
//   IFID_Instr/PC/PCPlus/Valid : IF/ID pipeline register contents
//   FlushCount               : saturating count of honoured redirects
module fetch_redirect_unit #(
    parameter int PC_W = 16,
    parameter int INSTR_W = 16,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] PC_INC = 2,
    parameter logic [INSTR_W-1:0] NOP = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               BranchingSoFlush,
    input  logic [PC_W-1:0]    BranchTarget,
    input  logic               Stall,
    output logic [PC_W-1:0]    InstrAddr,
    input  logic [INSTR_W-1:0] InstrData,
    output logic [INSTR_W-1:0] IFID_Instr,
    output logic [PC_W-1:0]    IFID_PC,
    output logic [PC_W-1:0]    IFID_PCPlus,
    output logic               IFID_Valid,
    output logic [7:0]         FlushCount
);
    typedef enum logic {BOOT, RUN} state_t;
    state_t state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, ifid_pcplus_q, ifid_pcplus_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic ifid_valid_q, ifid_valid_d;
    logic [7:0] flush_count_q, flush_count_d;
    logic run, flush, fetch;
    assign run = state_q == RUN;
    assign flush = run && BranchingSoFlush;
    assign fetch = run && !BranchingSoFlush && !Stall;
    always_comb begin
        state_d = RUN;
        pc_d = flush ? {BranchTarget[PC_W-1:1], 1'b0} : fetch ? pc_q + PC_INC : pc_q;
        ifid_instr_d = flush ? NOP : fetch ? InstrData : ifid_instr_q;
        ifid_pc_d = flush ? '0 : fetch ? pc_q : ifid_pc_q;
        ifid_pcplus_d = flush ? '0 : fetch ? pc_q + PC_INC : ifid_pcplus_q;
        ifid_valid_d = flush ? 1'b0 : fetch ? 1'b1 : ifid_valid_q;
        flush_count_d = (flush && flush_count_q != 8'hFF) ? flush_count_q + 8'd1 : flush_count_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q <= RESET_PC;
            ifid_instr_q <= NOP;
            ifid_pc_q <= '0;
            ifid_pcplus_q <= '0;
            ifid_valid_q <= 1'b0;
            flush_count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q <= ifid_pc_d;
            ifid_pcplus_q <= ifid_pcplus_d;
            ifid_valid_q <= ifid_valid_d;
            flush_count_q <= flush_count_d;
        end
    end
    assign InstrAddr = pc_q;
    assign IFID_Instr = ifid_instr_q;
    assign IFID_PC = ifid_pc_q;
    assign IFID_PCPlus = ifid_pcplus_q;
    assign IFID_Valid = ifid_valid_q;
    assign FlushCount = flush_count_q;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: directed stimulus with a per-cycle reference model and literal spot checks
module tb_fetch_redirect_unit;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, stall = 1'b0;
    logic [15:0] target = '0, addr, mask = '0, instr, ipc, iplus;
    logic valid;
    logic [7:0] fcount;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    fetch_redirect_unit dut (
        .clk(clk), .rst(rst), .BranchingSoFlush(flush), .BranchTarget(target), .Stall(stall),
        .InstrAddr(addr), .InstrData(addr ^ mask), .IFID_Instr(instr), .IFID_PC(ipc),
        .IFID_PCPlus(iplus), .IFID_Valid(valid), .FlushCount(fcount)
    );

    logic m_boot, m_valid;
    logic [15:0] m_pc, m_instr, m_ipc, m_iplus;
    int m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_boot <= 1'b1; m_pc <= 16'h0000; m_instr <= 16'h0000;
            m_ipc <= 16'h0000; m_iplus <= 16'h0000; m_valid <= 1'b0; m_cnt <= 0;
        end else if (m_boot) begin
            m_boot <= 1'b0;
        end else if (flush) begin
            m_pc <= target & 16'hFFFE; m_instr <= 16'h0000;
            m_ipc <= 16'h0000; m_iplus <= 16'h0000; m_valid <= 1'b0;
            m_cnt <= (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        end else if (!stall) begin
            m_instr <= m_pc ^ mask; m_ipc <= m_pc;
            m_iplus <= 16'((32'(m_pc) + 2) % 65536); m_valid <= 1'b1;
            m_pc <= 16'((32'(m_pc) + 2) % 65536);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        chk("m_addr", 32'(addr), 32'(m_pc));
        chk("m_instr", 32'(instr), 32'(m_instr));
        chk("m_ipc", 32'(ipc), 32'(m_ipc));
        chk("m_iplus", 32'(iplus), 32'(m_iplus));
        chk("m_valid", 32'(valid), 32'(m_valid));
        chk("m_count", 32'(fcount), 32'(m_cnt));
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        rst = 1'b0;
        cyc();
        chk("boot_valid", 32'(valid), 32'h0);
        chk("boot_addr", 32'(addr), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("run_pc", 32'(ipc), 32'(2 * i));
            chk("run_instr", 32'(instr), 32'(2 * i));
            chk("run_valid", 32'(valid), 32'h1);
        end
        chk("pc8", 32'(addr), 32'h8);
        flush = 1'b1; target = 16'h0041;
        cyc();
        flush = 1'b0;
        chk("redir_addr", 32'(addr), 32'h40);
        chk("redir_valid", 32'(valid), 32'h0);
        chk("redir_instr", 32'(instr), 32'h0);
        chk("redir_cnt", 32'(fcount), 32'h1);
        cyc();
        chk("redir_ipc", 32'(ipc), 32'h40);
        chk("redir_v1", 32'(valid), 32'h1);
        mask = 16'h5A00;
        flush = 1'b1; target = 16'h000C;
        cyc();
        flush = 1'b0;
        cyc(2);
        chk("pre_stall_addr", 32'(addr), 32'h10);
        stall = 1'b1;
        cyc(3);
        chk("stall_addr", 32'(addr), 32'h10);
        chk("stall_ipc", 32'(ipc), 32'h0E);
        chk("stall_instr", 32'(instr), 32'h5A0E);
        stall = 1'b0;
        cyc();
        chk("resume_ipc", 32'(ipc), 32'h10);
        chk("resume_instr", 32'(instr), 32'h5A10);
        cyc();
        chk("resume_next", 32'(ipc), 32'h12);
        flush = 1'b1; stall = 1'b1; target = 16'h0100;
        cyc();
        chk("fs_addr", 32'(addr), 32'h100);
        chk("fs_valid", 32'(valid), 32'h0);
        chk("fs_cnt", 32'(fcount), 32'h3);
        cyc(299);
        chk("sat_cnt", 32'(fcount), 32'hFF);
        stall = 1'b0; target = 16'hFFFE;
        cyc();
        flush = 1'b0;
        chk("wrap_addr0", 32'(addr), 32'hFFFE);
        cyc();
        chk("wrap_ipc", 32'(ipc), 32'hFFFE);
        chk("wrap_plus", 32'(iplus), 32'h0);
        chk("wrap_addr", 32'(addr), 32'h0);
        chk("wrap_cnt", 32'(fcount), 32'hFF);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc(2);
        flush = 1'b1; target = 16'h0020;
        cyc(5);
        flush = 1'b0;
        cyc();
        chk("pre_rst_valid", 32'(valid), 32'h1);
        chk("pre_rst_cnt", 32'(fcount), 32'h5);
        flush = 1'b1; target = 16'h0300;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_cnt", 32'(fcount), 32'h0);
        chk("arst_addr", 32'(addr), 32'h0);
        chk("arst_ipc", 32'(ipc), 32'h0);
        chk("arst_instr", 32'(instr), 32'h0);
        flush = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("reboot_valid", 32'(valid), 32'h0);
        chk("reboot_addr", 32'(addr), 32'h0);
        cyc();
        chk("reboot_v1", 32'(valid), 32'h1);
        chk("reboot_ipc", 32'(ipc), 32'h0);
        chk("reboot_instr", 32'(instr), 32'h5A00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
